// File: rtl/cache_lv1_il_assoc_if.sv
// rtl/cache_lv1_il_assoc_if.sv - CPU fetch port and L1-L2 bus signals of the L1 instruction cache
interface cache_lv1_il_assoc_if #(
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 32
);
  logic                cpu_rd;
  logic [ADDR_WID-1:0] addr_bus_cpu_lv1;
  logic                data_in_bus_cpu_lv1_il;
  logic                bus_lv1_lv2_req_proc_il;
  logic                bus_lv1_lv2_gnt_proc;
  logic                lv2_rd;
  logic [ADDR_WID-1:0] addr_bus_lv1_lv2;
  logic [DATA_WID-1:0] data_bus_lv1_lv2;
  logic                data_in_bus_lv1_lv2;

  modport master (
    input  cpu_rd, addr_bus_cpu_lv1, bus_lv1_lv2_gnt_proc, data_bus_lv1_lv2, data_in_bus_lv1_lv2,
    output data_in_bus_cpu_lv1_il, bus_lv1_lv2_req_proc_il, lv2_rd, addr_bus_lv1_lv2
  );

  modport slave (
    output cpu_rd, addr_bus_cpu_lv1, bus_lv1_lv2_gnt_proc, data_bus_lv1_lv2, data_in_bus_lv1_lv2,
    input  data_in_bus_cpu_lv1_il, bus_lv1_lv2_req_proc_il, lv2_rd, addr_bus_lv1_lv2
  );
endinterface

// File: rtl/cache_lv1_il_assoc.sv
// rtl/cache_lv1_il_assoc.sv - set-associative L1 instruction cache with burst line fill and true LRU
// Optional hit/miss counters enabled by defining CACHE_LV1_IL_STATS_EN.
module cache_lv1_il_assoc #(
  parameter int ASSOC          = 4,
  parameter int NUM_OF_SETS    = 256,
  parameter int WORDS_PER_LINE = 4,
  parameter int DATA_WID       = 32,
  parameter int ADDR_WID       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_lv1_il_assoc_if.master bus,
  inout  wire  [DATA_WID-1:0]  data_bus_cpu_lv1
`ifdef CACHE_LV1_IL_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NUM_OF_SETS);
  localparam int TW = ADDR_WID - OW - IW;
  localparam int AW = $clog2(ASSOC);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [ADDR_WID-1:0] addr_q;
  logic [OW:0]         beat_q;
  logic [AW-1:0]       way_q;
  logic [DATA_WID-1:0] word_q;

  logic                valid_q [ASSOC][NUM_OF_SETS];
  logic [TW-1:0]       tag_q   [ASSOC][NUM_OF_SETS];
  logic [AW-1:0]       age_q   [ASSOC][NUM_OF_SETS];
  logic [DATA_WID-1:0] data_q  [ASSOC][NUM_OF_SETS][WORDS_PER_LINE];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [OW-1:0] off;
  assign off = addr_q[OW-1:0];
  assign idx = addr_q[OW+IW-1:OW];
  assign tag = addr_q[ADDR_WID-1:OW+IW];

  logic          hit, vic_found;
  logic [AW-1:0] hit_way, vic_way, lru_way, lru_old;
  logic          beat_fire, last_beat, lru_upd;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    vic_found = 1'b0;
    vic_way   = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
      if (!vic_found && !valid_q[w][idx]) begin
        vic_found = 1'b1;
        vic_way   = AW'(w);
      end
    end
    // With every way valid the oldest (age ASSOC-1) is evicted; ages are a permutation.
    if (!vic_found) begin
      for (int w = 0; w < ASSOC; w++) begin
        if (age_q[w][idx] == AW'(ASSOC - 1)) vic_way = AW'(w);
      end
    end
  end

  assign beat_fire = (state_q == S_FILL) && bus.data_in_bus_lv1_lv2;
  assign last_beat = beat_fire && (beat_q == (OW+1)'(WORDS_PER_LINE - 1));
  assign lru_upd   = ((state_q == S_LOOKUP) && hit) || last_beat;
  assign lru_way   = (state_q == S_LOOKUP) ? hit_way : way_q;
  assign lru_old   = age_q[lru_way][idx];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cpu_rd) state_d = S_LOOKUP;
      S_LOOKUP: state_d = hit ? S_RESP : S_REQ;
      S_REQ:    if (bus.bus_lv1_lv2_gnt_proc) state_d = S_FILL;
      S_FILL:   if (last_beat) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      way_q   <= '0;
      word_q  <= '0;
      for (int w = 0; w < ASSOC; w++) begin
        for (int s = 0; s < NUM_OF_SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          age_q[w][s]   <= AW'(w);
        end
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.cpu_rd) addr_q <= bus.addr_bus_cpu_lv1;
      if (state_q == S_LOOKUP) begin
        way_q <= hit ? hit_way : vic_way;
        if (hit) word_q <= data_q[hit_way][idx][off];
      end
      if (state_q == S_REQ && bus.bus_lv1_lv2_gnt_proc) beat_q <= '0;
      if (beat_fire) beat_q <= beat_q + 1'b1;
      // Earlier beats are already in the array; only the final one bypasses it.
      if (last_beat) begin
        valid_q[way_q][idx] <= 1'b1;
        tag_q[way_q][idx]   <= tag;
        word_q <= (off == OW'(WORDS_PER_LINE - 1)) ? bus.data_bus_lv1_lv2 : data_q[way_q][idx][off];
      end
      if (lru_upd) begin
        for (int w = 0; w < ASSOC; w++) begin
          if (AW'(w) == lru_way)        age_q[w][idx] <= '0;
          else if (age_q[w][idx] < lru_old) age_q[w][idx] <= age_q[w][idx] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire) data_q[way_q][idx][beat_q[OW-1:0]] <= bus.data_bus_lv1_lv2;
  end

`ifdef CACHE_LV1_IL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit && hit_cnt != 32'hFFFF_FFFF)       hit_cnt  <= hit_cnt + 1'b1;
      if (!hit && miss_cnt != 32'hFFFF_FFFF)     miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

  assign bus.bus_lv1_lv2_req_proc_il = (state_q == S_REQ) || (state_q == S_FILL);
  assign bus.lv2_rd                  = (state_q == S_FILL);
  assign bus.addr_bus_lv1_lv2        = (state_q == S_FILL) ? {tag, idx, {OW{1'b0}}} : '0;
  assign bus.data_in_bus_cpu_lv1_il  = (state_q == S_RESP);
  assign data_bus_cpu_lv1            = (state_q == S_RESP) ? word_q : {DATA_WID{1'bz}};
endmodule
